uart_tx_port: RTL and testbench

//  Port-mapped 8N1 UART transmitter on the RAT MCU I/O bus, sitting beside LEDs/SevSeg in RAT_WRAPPER.

---
 rtl/rat_io_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_port.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_port.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rat_io_pkg.sv
// Shared definitions for the RAT MCU I/O bus: port addresses, UART TX state
// encoding and status-byte bit positions.
package rat_io_pkg;

    localparam logic [7:0] PORT_SWITCHES  = 8'h20;
    localparam logic [7:0] PORT_LEDS      = 8'h40;
    localparam logic [7:0] PORT_SEVSEG    = 8'h81;
    localparam logic [7:0] PORT_UART_TX   = 8'h50;
    localparam logic [7:0] PORT_UART_STAT = 8'h51;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_EMPTY  = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_CNT_LO = 4;
    localparam int STAT_CNT_HI = 6;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through output. A push while full
// is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push && (!full || pop);
    assign w_pop_ok  = pop && !empty;

    // NOTE: the storage array is deliberately left out of reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// Port-mapped 8N1 UART transmitter for the RAT MCU I/O bus: OUT writes are queued
// in a FIFO and serialised on TX; status is readable and TX_DONE marks a drained queue.
module uart_tx_port
    import rat_io_pkg::*;
#(
    parameter int         CLK_FREQ     = 50_000_000,
    parameter int         BAUD         = 115200,
    parameter logic [7:0] TX_PORT_ID   = PORT_UART_TX,
    parameter logic [7:0] STAT_PORT_ID = PORT_UART_STAT,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] STATUS_OUT,
    output logic       TX,
    output logic       TX_DONE
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
    localparam int BCW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);

    uart_state_t    r_state;
    uart_state_t    w_state_nxt;
    logic [BCW-1:0] r_baud_cnt;
    logic [BCW-1:0] w_baud_nxt;
    logic [2:0]     r_bit_cnt;
    logic [2:0]     w_bit_nxt;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_nxt;
    logic           r_tx;
    logic           w_tx_nxt;
    logic           r_tx_done;
    logic           w_tx_done_nxt;
    logic           r_ovf;

    logic           w_wr;
    logic           w_clr;
    logic           w_ovf_set;
    logic           w_pop;
    logic           w_bit_end;
    logic [7:0]     w_fifo_dout;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [CW-1:0]  w_fifo_count;

    assign w_wr      = IO_STRB && (PORT_ID == TX_PORT_ID);
    assign w_clr     = IO_STRB && (PORT_ID == STAT_PORT_ID) && OUT_PORT[7];
    assign w_ovf_set = w_wr && w_fifo_full && !w_pop;
    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (w_wr),
        .pop   (w_pop),
        .din   (OUT_PORT),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud_cnt;
        w_bit_nxt     = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_tx_done_nxt = 1'b0;
        w_pop         = 1'b0;

        if (r_state != IDLE) begin
            w_baud_nxt = w_bit_end ? '0 : r_baud_cnt + 1'b1;
        end

        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_tx_nxt    = 1'b0;
                    w_baud_nxt  = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = '0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    // Refill straight from STOP so back-to-back frames have no idle gap.
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_tx_done_nxt = 1'b1;
                        w_state_nxt   = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_done  <= w_tx_done_nxt;
        end
    end

    // A fresh overflow takes priority over a clear landing on the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        STATUS_OUT                           = '0;
        STATUS_OUT[STAT_BUSY]                = (r_state != IDLE) || !w_fifo_empty;
        STATUS_OUT[STAT_FULL]                = w_fifo_full;
        STATUS_OUT[STAT_EMPTY]               = w_fifo_empty;
        STATUS_OUT[STAT_OVF]                 = r_ovf;
        STATUS_OUT[STAT_CNT_HI:STAT_CNT_LO]  = 3'(w_fifo_count);
    end

    assign TX      = r_tx;
    assign TX_DONE = r_tx_done;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: a frame-timeline reference model predicts
// TX, TX_DONE and STATUS_OUT every cycle under directed and random bus traffic.
module tb_uart_tx_port;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic [7:0] STATUS_OUT;
    logic       TX;
    logic       TX_DONE;

    uart_tx_port #(
        .CLK_FREQ     (400),
        .BAUD         (100),
        .TX_PORT_ID   (8'h50),
        .STAT_PORT_ID (8'h51),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .PORT_ID    (PORT_ID),
        .OUT_PORT   (OUT_PORT),
        .IO_STRB    (IO_STRB),
        .STATUS_OUT (STATUS_OUT),
        .TX         (TX),
        .TX_DONE    (TX_DONE)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of pending bytes plus the edge at which the current frame began.
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    bit         m_active;
    bit         m_ovf;
    bit         m_done;
    int         m_edge;
    int         m_p;

    function automatic void m_reset();
        m_q.delete();
        m_cur    = 8'h00;
        m_active = 1'b0;
        m_ovf    = 1'b0;
        m_done   = 1'b0;
        m_edge   = 0;
        m_p      = 0;
    endfunction

    function automatic void m_step(input logic strb, input logic [7:0] id, input logic [7:0] d);
        bit fin;
        bit pop_now;
        bit wr;
        bit clr;
        int sz;
        m_edge++;
        sz      = m_q.size();
        fin     = m_active && ((m_edge - m_p) == FRAME);
        pop_now = (!m_active || fin) && (sz > 0);
        wr      = strb && (id == 8'h50);
        clr     = strb && (id == 8'h51) && d[7];
        m_done  = fin && !pop_now;
        if (pop_now) begin
            m_cur    = m_q.pop_front();
            m_p      = m_edge;
            m_active = 1'b1;
        end else if (fin) begin
            m_active = 1'b0;
        end
        if (clr) m_ovf = 1'b0;
        if (wr) begin
            if (sz < DEPTH || pop_now) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endfunction

    function automatic logic m_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = (m_edge - m_p) / DIV;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        int sz;
        sz   = m_q.size();
        s    = 8'h00;
        s[0] = m_active || (sz != 0);
        s[1] = (sz == DEPTH);
        s[2] = (sz == 0);
        s[3] = m_ovf;
        s[6:4] = 3'(sz);
        return s;
    endfunction

    task automatic cycle(input logic strb, input logic [7:0] id, input logic [7:0] d);
        @(negedge CLK);
        IO_STRB  = strb;
        PORT_ID  = id;
        OUT_PORT = d;
        @(posedge CLK);
        m_step(strb, id, d);
        #1;
        check("tx", {7'b0, TX}, {7'b0, m_tx()});
        check("tx_done", {7'b0, TX_DONE}, {7'b0, m_done});
        check("status", STATUS_OUT, m_status());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00, 8'h00);
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        cycle(1'b1, id, d);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tx"}, {7'b0, TX}, 8'h01);
        check({tag, "_done"}, {7'b0, TX_DONE}, 8'h00);
        check({tag, "_status"}, STATUS_OUT, 8'h04);
    endtask

    initial begin
        int waited;
        logic [7:0] ids [5];
        ids[0] = 8'h50; ids[1] = 8'h51; ids[2] = 8'h20; ids[3] = 8'h40; ids[4] = 8'h81;
        m_reset();

        // Held in reset, then an idle line for 100 cycles.
        repeat (3) @(posedge CLK);
        #1;
        check_reset_state("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        idle(100);

        // Single 8'hA5 frame.
        wr(8'h50, 8'hA5);
        idle(FRAME + 5);

        // Five back-to-back writes, all sent without gaps.
        for (int i = 1; i <= 5; i++) wr(8'h50, 8'(i));
        idle(5 * FRAME + 10);

        // Six writes: sixth dropped, overflow sticky until cleared with bit7 set.
        for (int i = 0; i < 6; i++) wr(8'h50, 8'h10 + 8'(i));
        idle(10);
        check("t4_ovf", {7'b0, STATUS_OUT[3]}, 8'h01);
        wr(8'h51, 8'h7F);
        idle(3);
        wr(8'h51, 8'h80);
        check("t4_ovf_clr", {7'b0, STATUS_OUT[3]}, 8'h00);
        idle(5 * FRAME + 10);

        // Push while full on the exact STOP->START pop edge.
        for (int i = 0; i < 5; i++) wr(8'h50, 8'hC0 + 8'(i));
        waited = 0;
        while (!(m_active && (m_edge + 1 - m_p) == FRAME && m_q.size() == DEPTH) && waited < 200) begin
            idle(1);
            waited++;
        end
        if (waited >= 200) check("t5_wait_timeout", 8'h00, 8'h01);
        wr(8'h50, 8'hEE);
        check("t5_count", {5'b0, STATUS_OUT[6:4]}, 8'h04);
        check("t5_ovf", {7'b0, STATUS_OUT[3]}, 8'h00);
        idle(5 * FRAME + 10);

        // Asynchronous reset mid-DATA, then a clean frame.
        wr(8'h50, 8'h3C);
        idle(8);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_state("async_rst");
        m_reset();
        @(posedge CLK);
        #1;
        check_reset_state("rst_hold");
        @(negedge CLK);
        RST_N = 1'b1;
        wr(8'h50, 8'h55);
        idle(FRAME + 5);

        // Random bus traffic across all ports.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0)
                wr(ids[$urandom_range(0, 4)], 8'($urandom));
            else
                idle(1);
        end
        idle(5 * FRAME + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
